datapath_sequencer: RTL and testbench

- FSM controller that drives the 16-bit arithmetic Datapath's control inputs: SEL, MUX, LOAD, ENABLE and VALID.
- Runs a fixed iterative program: fetch, then a loop of add/sub, multiply, divide and accumulate, repeated until the datapath raises FLAG or an iteration limit is reached.
- Handles the multi-cycle multiplier via READY and a timeout.
- Exposes a START/DONE handshake to the upper-level control.

---
 rtl/datapath_sequencer_if.sv | 45 ++++
 rtl/datapath_sequencer.sv | 167 ++++++++++++++++
 tb/tb_datapath_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_sequencer_if.sv
// ---------------------------------------------------------------------------
// datapath_sequencer_if
// Groups the sequencer's control handshake and the datapath control word.
//   start  : begin program (upper-level control -> sequencer)
//   abort  : synchronous abort back to idle
//   flag   : datapath early-termination flag
//   ready  : datapath multiply-complete indication
//   sel    : [7:0] tristate bus-drive enables
//   mux    : [3:0] datapath mux selects
//   load   : [6:0] register loads, bit 6 starts the multiplier
//   enable : datapath counter increment
//   valid  : datapath result-output enable
//   busy   : program in progress
//   done   : one-cycle completion pulse
//   err    : sticky multiplier-timeout error
//   iter   : [ITER_W-1:0] completed loop iterations
// master = the side that drives start/abort/flag/ready; slave = the sequencer.
// ---------------------------------------------------------------------------
interface datapath_sequencer_if #(
  parameter int ITER_W = 8
);
  logic              start;
  logic              abort;
  logic              flag;
  logic              ready;
  logic [7:0]        sel;
  logic [3:0]        mux;
  logic [6:0]        load;
  logic              enable;
  logic              valid;
  logic              busy;
  logic              done;
  logic              err;
  logic [ITER_W-1:0] iter;

  modport master (
    output start, abort, flag, ready,
    input  sel, mux, load, enable, valid, busy, done, err, iter
  );

  modport slave (
    input  start, abort, flag, ready,
    output sel, mux, load, enable, valid, busy, done, err, iter
  );
endinterface

// File: rtl/datapath_sequencer.sv
// ---------------------------------------------------------------------------
// datapath_sequencer
// FSM controller for the 16-bit arithmetic datapath. Runs fetch, then a loop
// of add/sub, multiply (waiting on ready with a timeout), divide and
// accumulate until the datapath raises flag or MAX_ITER iterations complete.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : datapath_sequencer_if.slave (start/abort/flag/ready in,
//         sel/mux/load/enable/valid/busy/done/err/iter out)
// Every output is a register loaded from the decode of the next state, so a
// control word is present exactly while the state register holds its state.
// ---------------------------------------------------------------------------
module datapath_sequencer #(
  parameter int MAX_ITER    = 8,
  parameter int MUL_TIMEOUT = 32,
  parameter int ITER_W      = 8
) (
  input logic                 clk,
  input logic                 rst,
  datapath_sequencer_if.slave bus
);

  localparam int WAIT_W = (MUL_TIMEOUT > 1) ? $clog2(MUL_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MUL_TIMEOUT - 1);
  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);
  localparam logic [ITER_W-1:0] ITER_SAT   = {ITER_W{1'b1}};

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_ADDSUB   = 4'd2,
    S_MUL_GO   = 4'd3,
    S_MUL_WAIT = 4'd4,
    S_DIV      = 4'd5,
    S_ACC      = 4'd6,
    S_CHECK    = 4'd7,
    S_DONE     = 4'd8,
    S_ERROR    = 4'd9
  } state_t;

  typedef struct packed {
    logic [7:0] sel;
    logic [3:0] mux;
    logic [6:0] load;
    logic       enable;
    logic       valid;
    logic       busy;
    logic       done;
    logic       err;
  } ctrl_t;

  // Control word emitted while the state register holds state s.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_IDLE:     c = '0;
      S_FETCH:    begin c.sel = 8'h03; c.mux = 4'h1; c.load = 7'h01; c.busy = 1'b1; end
      S_ADDSUB:   begin c.sel = 8'h14; c.mux = 4'h2; c.load = 7'h02; c.busy = 1'b1; end
      S_MUL_GO:   begin c.sel = 8'h28; c.mux = 4'h0; c.load = 7'h40; c.busy = 1'b1; end
      S_MUL_WAIT: begin c.sel = 8'h28; c.mux = 4'h0; c.load = 7'h00; c.busy = 1'b1; end
      S_DIV:      begin c.sel = 8'h18; c.mux = 4'h4; c.load = 7'h14; c.busy = 1'b1; end
      S_ACC:      begin c.sel = 8'h80; c.mux = 4'h8; c.load = 7'h20; c.enable = 1'b1; c.busy = 1'b1; end
      S_CHECK:    c.busy = 1'b1;
      S_DONE:     begin c.valid = 1'b1; c.done = 1'b1; c.busy = 1'b1; end
      S_ERROR:    c.err = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  state_t              state_r;
  state_t              next_state_s;
  logic [WAIT_W-1:0]   wait_cnt_r;
  logic [WAIT_W-1:0]   wait_cnt_nxt_s;
  logic [ITER_W-1:0]   iter_r;
  logic [ITER_W-1:0]   iter_nxt_s;
  ctrl_t               ctrl_r;

  // Next-state, wait-counter and iteration-counter logic; abort overrides all.
  always_comb begin
    next_state_s   = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    iter_nxt_s     = iter_r;
    if (bus.abort) begin
      next_state_s   = S_IDLE;
      wait_cnt_nxt_s = '0;
      iter_nxt_s     = '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            next_state_s = S_FETCH;
          end else begin
            next_state_s = S_IDLE;
          end
        end
        S_FETCH: begin
          iter_nxt_s   = '0;
          next_state_s = S_ADDSUB;
        end
        S_ADDSUB: next_state_s = S_MUL_GO;
        S_MUL_GO: begin
          wait_cnt_nxt_s = '0;
          next_state_s   = S_MUL_WAIT;
        end
        S_MUL_WAIT: begin
          // ready is checked first so it wins over a coincident timeout.
          if (bus.ready) begin
            next_state_s = S_DIV;
          end else if (wait_cnt_r == WAIT_LAST) begin
            next_state_s = S_ERROR;
          end else begin
            wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
            next_state_s   = S_MUL_WAIT;
          end
        end
        S_DIV: next_state_s = S_ACC;
        S_ACC: begin
          if (iter_r != ITER_SAT) begin
            iter_nxt_s = iter_r + ITER_W'(1);
          end else begin
            iter_nxt_s = iter_r;
          end
          next_state_s = S_CHECK;
        end
        S_CHECK: begin
          if (bus.flag || (iter_r == ITER_LIMIT)) begin
            next_state_s = S_DONE;
          end else begin
            next_state_s = S_ADDSUB;
          end
        end
        S_DONE:  next_state_s = S_IDLE;
        S_ERROR: next_state_s = S_ERROR;
        default: next_state_s = S_IDLE;
      endcase
    end
  end

  // State, counters and registered control word (decoded from next state).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      wait_cnt_r <= '0;
      iter_r     <= '0;
      ctrl_r     <= '0;
    end else begin
      state_r    <= next_state_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      iter_r     <= iter_nxt_s;
      ctrl_r     <= decode(next_state_s);
    end
  end

  assign bus.sel    = ctrl_r.sel;
  assign bus.mux    = ctrl_r.mux;
  assign bus.load   = ctrl_r.load;
  assign bus.enable = ctrl_r.enable;
  assign bus.valid  = ctrl_r.valid;
  assign bus.busy   = ctrl_r.busy;
  assign bus.done   = ctrl_r.done;
  assign bus.err    = ctrl_r.err;
  assign bus.iter   = iter_r;

endmodule

// File: tb/tb_datapath_sequencer.sv
// ---------------------------------------------------------------------------
// tb_datapath_sequencer
// Drives two sequencers (MAX_ITER=4 and MAX_ITER=1, MUL_TIMEOUT=32) from a
// shared set of inputs. Each program is planned as a list of expected steps
// (one per clock cycle: which control word should be visible and which inputs
// to apply), built from the program shape: fetch, per-iteration blocks of
// add/sub, mul-go, (delay+1) mul-wait, div, acc, check, then done.
// ---------------------------------------------------------------------------
module tb_datapath_sequencer;

  localparam int K_IDLE = 0, K_FETCH = 1, K_ADDSUB = 2, K_MUL_GO = 3,
                 K_MUL_WAIT = 4, K_DIV = 5, K_ACC = 6, K_CHECK = 7,
                 K_DONE = 8, K_ERROR = 9;

  typedef struct {
    int kind;
    bit rdy;
    bit flg;
    bit st;
    bit ab;
    int it;
  } step_t;

  logic clk = 1'b0;
  logic rst;
  logic start_s, abort_s, flag_s, ready_s;

  int checks = 0;
  int errors = 0;
  bit noise = 1'b0;
  bit hold_start = 1'b0;
  bit use1 = 1'b0;
  step_t plan[$];

  always #5 clk = ~clk;

  datapath_sequencer_if #(.ITER_W(8)) bus4 ();
  datapath_sequencer_if #(.ITER_W(8)) bus1 ();

  assign bus4.start = start_s;
  assign bus4.abort = abort_s;
  assign bus4.flag  = flag_s;
  assign bus4.ready = ready_s;
  assign bus1.start = start_s;
  assign bus1.abort = abort_s;
  assign bus1.flag  = flag_s;
  assign bus1.ready = ready_s;

  datapath_sequencer #(.MAX_ITER(4), .MUL_TIMEOUT(32), .ITER_W(8)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );
  datapath_sequencer #(.MAX_ITER(1), .MUL_TIMEOUT(32), .ITER_W(8)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  // {sel, mux, load, enable, valid, busy, done, err}
  function automatic logic [23:0] word_of(input int kind);
    case (kind)
      K_FETCH:    return {8'h03, 4'h1, 7'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      K_ADDSUB:   return {8'h14, 4'h2, 7'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      K_MUL_GO:   return {8'h28, 4'h0, 7'h40, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      K_MUL_WAIT: return {8'h28, 4'h0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      K_DIV:      return {8'h18, 4'h4, 7'h14, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      K_ACC:      return {8'h80, 4'h8, 7'h20, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      K_CHECK:    return {8'h00, 4'h0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      K_DONE:     return {8'h00, 4'h0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      K_ERROR:    return {8'h00, 4'h0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      default:    return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] obs_word();
    if (use1)
      return {bus1.sel, bus1.mux, bus1.load, bus1.enable, bus1.valid, bus1.busy, bus1.done, bus1.err};
    else
      return {bus4.sel, bus4.mux, bus4.load, bus4.enable, bus4.valid, bus4.busy, bus4.done, bus4.err};
  endfunction

  function automatic logic [7:0] obs_iter();
    return use1 ? bus1.iter : bus4.iter;
  endfunction

  function automatic bit rnd();
    return noise ? (($urandom & 32'd1) != 32'd0) : 1'b0;
  endfunction

  task automatic chk_word(input string tag, input logic [23:0] o, input logic [23:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s word observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk_iter(input string tag, input logic [7:0] o, input logic [7:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s iter observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic push(input int kind, input bit rdy, input bit flg, input int it);
    step_t s;
    s.kind = kind;
    s.rdy  = rdy;
    s.flg  = flg;
    s.st   = noise ? rnd() : hold_start;
    s.ab   = 1'b0;
    s.it   = it;
    plan.push_back(s);
  endtask

  // One loop iteration with d cycles of ready low before ready rises.
  task automatic plan_iter(input int d, input bit chk_flag);
    push(K_ADDSUB, rnd(), rnd(), -1);
    push(K_MUL_GO, rnd(), rnd(), -1);
    for (int j = 0; j < d; j++) push(K_MUL_WAIT, 1'b0, rnd(), -1);
    push(K_MUL_WAIT, 1'b1, rnd(), -1);
    push(K_DIV, rnd(), rnd(), -1);
    push(K_ACC, rnd(), rnd(), -1);
    push(K_CHECK, rnd(), chk_flag, -1);
  endtask

  // Full program of k iterations on a sequencer whose limit is maxk.
  task automatic plan_prog(input int k, input int maxk, input int dlo, input int dhi);
    push(K_FETCH, rnd(), rnd(), -1);
    for (int i = 1; i <= k; i++) begin
      plan_iter(int'($urandom_range(dhi, dlo)),
                (i == k) ? ((k < maxk) ? 1'b1 : rnd()) : 1'b0);
    end
    push(K_DONE, rnd(), rnd(), k);
    push(K_IDLE, rnd(), rnd(), k);
    plan[$].st = 1'b0;
  endtask

  task automatic exec_plan(input string tag);
    foreach (plan[i]) begin
      @(posedge clk);
      #1;
      chk_word(tag, obs_word(), word_of(plan[i].kind));
      if (plan[i].it >= 0) chk_iter(tag, obs_iter(), 8'(plan[i].it));
      start_s = plan[i].st;
      ready_s = plan[i].rdy;
      flag_s  = plan[i].flg;
      abort_s = plan[i].ab;
    end
    plan.delete();
  endtask

  // Checks an idle cycle and requests a start at its closing edge.
  task automatic begin_run(input string tag);
    @(posedge clk);
    #1;
    chk_word(tag, obs_word(), word_of(K_IDLE));
    start_s = 1'b1;
    ready_s = rnd();
    flag_s  = rnd();
    abort_s = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start_s = 1'b0;
    abort_s = 1'b0;
    flag_s  = 1'b0;
    ready_s = 1'b0;
    #3;
    chk_word("reset", obs_word(), 24'h000000);
    chk_iter("reset", obs_iter(), 8'd0);
    #9 rst = 1'b0;

    // Full four-iteration program, ready immediate, flag low.
    begin_run("idle_a");
    plan_prog(4, 4, 0, 0);
    exec_plan("max_iter4");

    // Flag in the first check ends after one iteration.
    begin_run("idle_b");
    plan_prog(1, 4, 0, 0);
    exec_plan("flag_first");

    // Ready delayed five cycles in every mul-wait.
    begin_run("idle_c");
    plan_prog(2, 4, 5, 5);
    exec_plan("ready_dly5");

    // Randomized programs with noise on ignored inputs.
    noise = 1'b1;
    for (int r = 0; r < 12; r++) begin
      begin_run("idle_r");
      plan_prog(int'($urandom_range(4, 1)), 4, 0, 6);
      exec_plan("random");
    end
    noise = 1'b0;

    // Multiplier timeout: 32 wait cycles, sticky error, start ignored, abort.
    begin_run("idle_t");
    push(K_FETCH, 1'b0, 1'b0, -1);
    push(K_ADDSUB, 1'b0, 1'b0, -1);
    push(K_MUL_GO, 1'b0, 1'b0, -1);
    for (int j = 0; j < 32; j++) push(K_MUL_WAIT, 1'b0, 1'b0, -1);
    hold_start = 1'b1;
    for (int j = 0; j < 4; j++) push(K_ERROR, 1'b1, 1'b1, 0);
    plan[$].ab = 1'b1;
    hold_start = 1'b0;
    push(K_IDLE, 1'b0, 1'b0, 0);
    exec_plan("timeout");

    // Asynchronous reset while waiting on the multiplier in iteration two.
    begin_run("idle_x");
    push(K_FETCH, 1'b0, 1'b0, -1);
    plan_iter(0, 1'b0);
    push(K_ADDSUB, 1'b0, 1'b0, -1);
    push(K_MUL_GO, 1'b0, 1'b0, -1);
    push(K_MUL_WAIT, 1'b0, 1'b0, -1);
    push(K_MUL_WAIT, 1'b0, 1'b0, 1);
    exec_plan("pre_reset");
    #2 rst = 1'b1;
    #1;
    chk_word("async_reset", obs_word(), 24'h000000);
    chk_iter("async_reset", obs_iter(), 8'd0);
    #1 rst = 1'b0;

    // Back-to-back runs on the single-iteration sequencer, abort during acc.
    @(posedge clk);
    #1 abort_s = 1'b1;
    @(posedge clk);
    #1 abort_s = 1'b0;
    use1 = 1'b1;
    hold_start = 1'b1;
    begin_run("idle_b2b");
    push(K_FETCH, 1'b0, 1'b0, -1);
    plan_iter(0, 1'b0);
    push(K_DONE, 1'b0, 1'b0, 1);
    push(K_IDLE, 1'b0, 1'b0, 1);
    push(K_FETCH, 1'b0, 1'b0, -1);
    push(K_ADDSUB, 1'b0, 1'b0, -1);
    push(K_MUL_GO, 1'b0, 1'b0, -1);
    push(K_MUL_WAIT, 1'b1, 1'b0, -1);
    push(K_DIV, 1'b0, 1'b0, -1);
    push(K_ACC, 1'b0, 1'b0, -1);
    plan[$].ab = 1'b1;
    push(K_IDLE, 1'b0, 1'b0, 0);
    plan[$].st = 1'b0;
    push(K_IDLE, 1'b0, 1'b0, 0);
    plan[$].st = 1'b0;
    exec_plan("back_to_back");
    hold_start = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
